// File: rtl/id_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_controller
// Description : Stall and forwarding sequencer for an ID stage that resolves
//               branches early. Decodes the IF/ID instruction and compares its
//               source registers against the ID/EX and EX/MEM destinations to
//               drive the ID/EX bubble, the compare-operand forwarding muxes
//               and the PC / IF/ID write enables. A two-state FSM (RUN/HOLD)
//               covers the two-cycle load-to-branch case. Saturating counters
//               report stall cycles and hazard events to the debug path.
// Ports       : clock, reset        - rising-edge clock, async active-high reset
//               IFIDInstr           - instruction currently in ID
//               IDEX*               - ID/EX control bits and register fields
//               EXMEM*              - EX/MEM control bits and destination
//               CntClear            - synchronous clear of both counters
//               Hazard              - insert bubble into ID/EX
//               PCWrite, IFIDWrite  - PC and IF/ID update enables
//               forward1, forward2  - select EX/MEM result for rs / rt compare
//               BranchEnable        - permits ID to flush for taken beq / j
//               StallCycles         - saturating count of stalled cycles
//               HazardEvents        - saturating count of detected hazards
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      IFIDInstr,
    input  logic             IDEXMemRead,
    input  logic             IDEXRegWrite,
    input  logic             IDEXRegDst,
    input  logic [4:0]       IDEXRt,
    input  logic [4:0]       IDEXRd,
    input  logic             EXMEMRegWrite,
    input  logic             EXMEMMemRead,
    input  logic [4:0]       EXMEMDst,
    input  logic             CntClear,
    output logic             Hazard,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             forward1,
    output logic             forward2,
    output logic             BranchEnable,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] HazardEvents
);

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, event_cnt_q;

    logic [5:0] w_op;
    logic [4:0] w_rs, w_rt, w_idex_dst;
    logic       w_uses_rs, w_uses_rt, w_is_branch;
    logic       w_match_idex, w_match_exmem;
    logic       w_det1, w_det2, w_stall, w_event;
    logic       w_unused;

    // Immediate / shamt / funct bits play no part in hazard detection.
    assign w_unused = ^IFIDInstr[15:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_op        = IFIDInstr[31:26];
    assign w_rs        = IFIDInstr[25:21];
    assign w_rt        = IFIDInstr[20:16];
    assign w_uses_rs   = (w_op != C_OP_J);
    assign w_uses_rt   = (w_op == C_OP_RTYPE) || (w_op == C_OP_BEQ) || (w_op == C_OP_SW);
    assign w_is_branch = (w_op == C_OP_BEQ);
    assign w_idex_dst  = IDEXRegDst ? IDEXRd : IDEXRt;

    // Register 0 is hard-wired, so a zero destination can never create a hazard.
    function automatic logic reg_match(input logic [4:0] d, input logic urs,
                                       input logic urt, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (d != 5'd0) && ((urs && (d == rs)) || (urt && (d == rt)));
    endfunction

    assign w_match_idex  = reg_match(w_idex_dst, w_uses_rs, w_uses_rt, w_rs, w_rt);
    assign w_match_exmem = reg_match(EXMEMDst,   w_uses_rs, w_uses_rt, w_rs, w_rt);

    // A load feeding a branch needs the data two cycles later: stall now and
    // once more from HOLD while the load sits in MEM.
    assign w_det2 = w_is_branch && IDEXMemRead && IDEXRegWrite && w_match_idex;

    assign w_det1 = !w_det2 && (
                        (w_is_branch && IDEXRegWrite && !IDEXMemRead && w_match_idex) ||
                        (w_is_branch && EXMEMMemRead && w_match_exmem) ||
                        (!w_is_branch && IDEXMemRead && w_match_idex));

    // HOLD stalls unconditionally; detection is only evaluated in RUN.
    assign w_event = (state_q == ST_RUN) && (w_det1 || w_det2);
    assign w_stall = w_event || (state_q == ST_HOLD);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  state_d = w_det2 ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (forced to a safe, non-flushing value during reset)
    // ------------------------------------------------------------------
    always_comb begin
        Hazard       = 1'b0;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        forward1     = 1'b0;
        forward2     = 1'b0;
        BranchEnable = 1'b0;
        if (!reset) begin
            Hazard       = w_stall;
            PCWrite      = !w_stall;
            IFIDWrite    = !w_stall;
            BranchEnable = !w_stall;
            // Only ALU results are available in EX/MEM; load data is not.
            forward1     = EXMEMRegWrite && !EXMEMMemRead && (EXMEMDst != 5'd0) &&
                           (EXMEMDst == w_rs);
            forward2     = EXMEMRegWrite && !EXMEMMemRead && (EXMEMDst != 5'd0) &&
                           (EXMEMDst == w_rt);
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters; clear takes priority over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            event_cnt_q <= '0;
        end else if (CntClear) begin
            stall_cnt_q <= '0;
            event_cnt_q <= '0;
        end else begin
            if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + C_CNT_ONE;
            end
            if (w_event && (event_cnt_q != C_CNT_MAX)) begin
                event_cnt_q <= event_cnt_q + C_CNT_ONE;
            end
        end
    end

    assign StallCycles  = stall_cnt_q;
    assign HazardEvents = event_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_controller
// Description : Directed-vector bench for id_hazard_controller. The driver
//               pushes hand-computed expectations into a queue; a monitor
//               pops and compares them against a default-width instance and
//               a CNT_W=2 instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IFIDInstr;
    logic        IDEXMemRead, IDEXRegWrite, IDEXRegDst;
    logic [4:0]  IDEXRt, IDEXRd;
    logic        EXMEMRegWrite, EXMEMMemRead;
    logic [4:0]  EXMEMDst;
    logic        CntClear;

    logic        Hazard, PCWrite, IFIDWrite, forward1, forward2, BranchEnable;
    logic [15:0] StallCycles, HazardEvents;
    logic        Hazard2, PCWrite2, IFIDWrite2, forward1_2, forward2_2, BranchEnable2;
    logic [1:0]  StallCycles2, HazardEvents2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  id;
        logic        haz, pcw, be, fw1, fw2, chk2;
        logic [15:0] sc, he;
        logic [1:0]  sc2, he2;
    } exp_t;

    exp_t q[$];

    id_hazard_controller dut (
        .clock(clock), .reset(reset), .IFIDInstr(IFIDInstr),
        .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXRegDst(IDEXRegDst),
        .IDEXRt(IDEXRt), .IDEXRd(IDEXRd),
        .EXMEMRegWrite(EXMEMRegWrite), .EXMEMMemRead(EXMEMMemRead), .EXMEMDst(EXMEMDst),
        .CntClear(CntClear),
        .Hazard(Hazard), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .forward1(forward1), .forward2(forward2), .BranchEnable(BranchEnable),
        .StallCycles(StallCycles), .HazardEvents(HazardEvents)
    );

    id_hazard_controller #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .IFIDInstr(IFIDInstr),
        .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXRegDst(IDEXRegDst),
        .IDEXRt(IDEXRt), .IDEXRd(IDEXRd),
        .EXMEMRegWrite(EXMEMRegWrite), .EXMEMMemRead(EXMEMMemRead), .EXMEMDst(EXMEMDst),
        .CntClear(CntClear),
        .Hazard(Hazard2), .PCWrite(PCWrite2), .IFIDWrite(IFIDWrite2),
        .forward1(forward1_2), .forward2(forward2_2), .BranchEnable(BranchEnable2),
        .StallCycles(StallCycles2), .HazardEvents(HazardEvents2)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] I_ADD   = 32'h00432020; // add $4,$2,$3
    localparam logic [31:0] I_BEQ   = 32'h10430004; // beq $2,$3
    localparam logic [31:0] I_ADD0  = 32'h00002020; // add $4,$0,$0
    localparam logic [31:0] I_JFLD  = 32'h08430000; // j with rs/rt-position bits set
    localparam logic [31:0] I_J     = 32'h08000002; // j

    task automatic cmp(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec%0d actual=%0h required=%0h", nm, id, act, exp);
        end
    endtask

    // Monitor: checks queued expectations away from the rising edge, and
    // also right after an asynchronous reset rise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or posedge reset);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp("Hazard",       int'(e.id), {15'd0, Hazard},       {15'd0, e.haz});
                cmp("PCWrite",      int'(e.id), {15'd0, PCWrite},      {15'd0, e.pcw});
                cmp("IFIDWrite",    int'(e.id), {15'd0, IFIDWrite},    {15'd0, e.pcw});
                cmp("BranchEnable", int'(e.id), {15'd0, BranchEnable}, {15'd0, e.be});
                cmp("forward1",     int'(e.id), {15'd0, forward1},     {15'd0, e.fw1});
                cmp("forward2",     int'(e.id), {15'd0, forward2},     {15'd0, e.fw2});
                cmp("StallCycles",  int'(e.id), StallCycles,           e.sc);
                cmp("HazardEvents", int'(e.id), HazardEvents,          e.he);
                if (e.chk2) begin
                    cmp("StallCycles_w2",  int'(e.id), {14'd0, StallCycles2},  {14'd0, e.sc2});
                    cmp("HazardEvents_w2", int'(e.id), {14'd0, HazardEvents2}, {14'd0, e.he2});
                    cmp("Hazard_w2",       int'(e.id), {15'd0, Hazard2},       {15'd0, e.haz});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic imr, input logic irw,
                         input logic idst, input logic [4:0] rt, input logic [4:0] rd,
                         input logic erw, input logic emr, input logic [4:0] edst);
        IFIDInstr     = instr;
        IDEXMemRead   = imr;
        IDEXRegWrite  = irw;
        IDEXRegDst    = idst;
        IDEXRt        = rt;
        IDEXRd        = rd;
        EXMEMRegWrite = erw;
        EXMEMMemRead  = emr;
        EXMEMDst      = edst;
    endtask

    task automatic expect_v(input int id, input logic haz, input logic pcw, input logic be,
                            input logic fw1, input logic fw2, input logic [15:0] sc,
                            input logic [15:0] he, input logic chk2, input logic [1:0] sc2,
                            input logic [1:0] he2);
        exp_t e;
        e.id = id[7:0]; e.haz = haz; e.pcw = pcw; e.be = be; e.fw1 = fw1; e.fw2 = fw2;
        e.sc = sc; e.he = he; e.chk2 = chk2; e.sc2 = sc2; e.he2 = he2;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        CntClear = 1'b0;
        // Inputs that would stall and forward if not in reset
        drive(I_ADD, 1, 1, 0, 5'd2, 5'd0, 1, 0, 5'd3);
        #2;
        expect_v(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        expect_v(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        reset = 1'b0;

        // Load-use, non-branch: one stall
        drive(I_ADD, 1, 1, 0, 5'd2, 5'd0, 0, 0, 5'd0);
        expect_v(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(I_ADD, 0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd2);
        expect_v(3, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        tick();

        // Load then dependent beq: RUN -> HOLD -> RUN
        drive(I_BEQ, 1, 1, 0, 5'd3, 5'd0, 0, 0, 5'd0);
        expect_v(4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd3);
        expect_v(5, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0);
        tick();
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0);
        expect_v(6, 0, 1, 1, 0, 0, 3, 2, 0, 0, 0);
        tick();

        // ALU result into beq: one stall, then forward rs
        drive(I_BEQ, 0, 1, 1, 5'd7, 5'd2, 0, 0, 5'd0);
        expect_v(7, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0);
        tick();
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd2);
        expect_v(8, 0, 1, 1, 1, 0, 4, 3, 0, 0, 0);
        tick();
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 1, 0, 5'd3);
        expect_v(9, 0, 1, 1, 0, 1, 4, 3, 0, 0, 0);
        tick();

        // Register 0 never stalls or forwards
        drive(I_ADD0, 1, 1, 0, 5'd0, 5'd0, 1, 0, 5'd0);
        expect_v(10, 0, 1, 1, 0, 0, 4, 3, 0, 0, 0);
        tick();
        // beq with a load in MEM: one stall, no forward of load data
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd2);
        expect_v(11, 1, 0, 0, 0, 0, 4, 3, 0, 0, 0);
        tick();
        // j reads no registers: no load-use stall
        drive(I_JFLD, 1, 1, 0, 5'd2, 5'd0, 0, 0, 5'd0);
        expect_v(12, 0, 1, 1, 0, 0, 5, 4, 0, 0, 0);
        tick();

        // Enter HOLD, then reset mid-cycle
        drive(I_BEQ, 1, 1, 0, 5'd3, 5'd0, 0, 0, 5'd0);
        expect_v(13, 1, 0, 0, 0, 0, 5, 4, 0, 0, 0);
        tick();
        drive(I_J, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0);
        expect_v(14, 1, 0, 0, 0, 0, 6, 5, 0, 0, 0);
        #6;
        expect_v(15, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        drive(I_BEQ, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0);
        expect_v(16, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        tick();

        // Saturation on the 2-bit instance, clear during a stall
        drive(I_ADD, 1, 1, 0, 5'd2, 5'd0, 0, 0, 5'd0);
        for (int i = 0; i <= 6; i++) begin
            CntClear = (i == 6);
            expect_v(17 + i, 1, 0, 0, 0, 0, 16'(i), 16'(i), 1,
                     (i > 3) ? 2'd3 : 2'(i), (i > 3) ? 2'd3 : 2'(i));
            tick();
        end
        CntClear = 1'b0;
        expect_v(24, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(I_ADD, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0);
        expect_v(25, 0, 1, 1, 0, 0, 1, 1, 1, 2'd1, 2'd1);
        tick();
        tick();
        tick();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
